core_seq_ctrl: RTL and testbench
================================

Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath: steps each instruction through fetch, decode, execute, memory and write-back.
- Issues memory handshakes, register-file write enables and PC update strobes, and counts retired instructions.
- Sits between the instruction decoder and the register file, ALU and memory ports.
- Register-file reads are registered, so DECODE is one cycle that lets operands settle before EXEC.

Parameters:
- TIMEOUT, 16, max cycles a request is held without ack before trapping; 0 disables the timeout.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- imem_ack  in  1  instruction memory ack; instruction word valid this cycle.
- dmem_ack  in  1  data memory ack.
- dec_is_load  in  1  decoder: load.
- dec_is_store  in  1  decoder: store.
- dec_wb_en  in  1  decoder: instruction writes rd.
- dec_rd  in  5  decoder: destination register.
- dec_jump  in  1  decoder: jal/jalr or taken branch.
- dec_halt  in  1  decoder: ecall/ebreak.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  latch instruction register.
- dmem_req  out  1  data request.
- dmem_we  out  1  data write (store).
- rf_write_en  out  1  register-file write enable.
- rf_write_addr  out  5  register-file write address.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  0 = pc+4, 1 = jump/branch target.
- stage  out  3  current state encoding.
- halted  out  1  in HALT.
- trap  out  1  in TRAP.
- trap_cause  out  1  0 = fetch timeout, 1 = data timeout.
- instret  out  32  retired-instruction count.

Behaviour:
- Reset: synchronous, active-high; clock and reset are the single clk and reset ports.
  - State -> FETCH; wait counter, latched decode flags, instret, trap_cause -> 0.
  - While reset is high, all strobes are 0 (imem_req, ir_we, dmem_req, dmem_we, rf_write_en, pc_we, pc_sel, halted, trap).
  - rf_write_addr = 0 during reset.
  - Reset from any state, including mid-handshake, returns to FETCH the next cycle with no write or PC strobe.
  - First cycle after reset deasserts: stage = FETCH, imem_req = 1.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5, TRAP = 6. Outputs decode from the state register plus latched flags (Moore).
- FETCH:
  - imem_req = 1; ir_we = imem_ack.
  - On imem_ack -> DECODE; ack in the first request cycle is legal (single-cycle fetch).
- DECODE:
  - One cycle.
  - Latches dec_is_load, dec_is_store, dec_wb_en, dec_rd, dec_jump, dec_halt into internal flags.
  - Decoder inputs are ignored in all other states.
  - -> EXEC.
- EXEC:
  - One cycle, no strobes.
  - -> MEM if load or store, else -> WB.
- MEM:
  - dmem_req = 1; dmem_we = latched store.
  - On dmem_ack -> WB.
- WB:
  - One cycle.
  - rf_write_en = latched wb_en AND rd != 0; rf_write_addr = latched rd.
  - Store: rf_write_en = 0.
  - pc_we = 1; pc_sel = latched jump.
  - instret increments by 1, wrapping 0xFFFFFFFF -> 0.
  - -> HALT if latched halt, else -> FETCH.
  - A halt instruction still retires and updates the PC.
- HALT: halted = 1, all strobes 0; leaves only via reset.
- TRAP: trap = 1, all strobes 0, trap_cause held; leaves only via reset.
- Timeout (TIMEOUT > 0):
  - Wait counter clears on every entry to FETCH or MEM.
  - It increments each cycle the request is held without ack.
  - If no ack when counter == TIMEOUT-1 -> TRAP. The request is therefore held exactly TIMEOUT cycles.
  - Ack on that same final cycle wins: normal transition, no trap.
- Acks outside FETCH/MEM are ignored; a stray dmem_ack during FETCH does not advance.
- imem_ack and dmem_ack asserted together: only the ack for the current state is honoured.

Test Plan:
- ALU op: reset 2 cycles, imem_ack in first FETCH cycle, dec_wb_en = 1, dec_rd = 5 -> stage sequence 0,1,2,4,0; rf_write_en = 1 with addr 5 in WB; pc_we = 1, pc_sel = 0; instret = 1.
- Load with dmem_ack delayed 3 cycles:
  - MEM lasts 4 cycles with dmem_req = 1, dmem_we = 0.
  - Then WB writes rd.
  - Store variant: dmem_we = 1 and rf_write_en = 0 in WB.
- rd = 0 with dec_wb_en = 1 -> rf_write_en stays 0. dec_jump = 1 -> pc_sel = 1 in WB.
- TIMEOUT = 16:
  - No imem_ack -> imem_req high exactly 16 cycles, then stage = 6, trap = 1, trap_cause = 0.
  - Ack on the 16th cycle -> DECODE, no trap.
  - Data-side equivalent gives trap_cause = 1.
- dec_halt = 1 -> WB retires (instret +1, pc_we = 1), then halted = 1 with all strobes 0 for 10+ cycles; reset -> FETCH, instret = 0.
- Reset asserted mid-MEM with dmem_req = 1 -> next cycle stage = 0, no rf_write_en/pc_we pulse. Preload instret to 0xFFFFFFFF (via force), retire one -> instret = 0.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
// It drives the memory handshakes, register-file write enable and PC
// update strobes, and counts retired instructions. A request that waits
// too long for its ack parks the core in TRAP. A halt instruction parks
// it in HALT. Only reset leaves either of those states.
module core_seq_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_wb_en,
    input  logic [4:0]  dec_rd,
    input  logic        dec_jump,
    input  logic        dec_halt,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_write_en,
    output logic [4:0]  rf_write_addr,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [2:0]  stage,
    output logic        halted,
    output logic        trap,
    output logic        trap_cause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
    logic               trapCause_q, trapCause_d;
    logic               isLoad_q, isStore_q, wbEn_q, jump_q, halt_q;
    logic [4:0]         rd_q;
    logic [31:0]        instret_q;
    logic               timeoutHit;

    // A request gives up once it has been held TIMEOUT cycles.
    // A TIMEOUT of zero disables this limit.
    assign timeoutHit = (TIMEOUT != 0) && (waitCnt_q == CNT_W'(TIMEOUT - 1));

    // State, wait counter and trap cause update together on the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            waitCnt_q   <= '0;
            trapCause_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            waitCnt_q   <= waitCnt_d;
            trapCause_q <= trapCause_d;
        end
    end

    // Decoder outputs are captured only during the single DECODE cycle.
    // Later stages must not see the decoder change under them.
    always_ff @(posedge clk) begin
        if (reset) begin
            isLoad_q  <= 1'b0;
            isStore_q <= 1'b0;
            wbEn_q    <= 1'b0;
            rd_q      <= '0;
            jump_q    <= 1'b0;
            halt_q    <= 1'b0;
        end else if (state_q == S_DECODE) begin
            isLoad_q  <= dec_is_load;
            isStore_q <= dec_is_store;
            wbEn_q    <= dec_wb_en;
            rd_q      <= dec_rd;
            jump_q    <= dec_jump;
            halt_q    <= dec_halt;
        end
    end

    // Every instruction retires in WB. The count wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (state_q == S_WB) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    // Next-state logic. The wait counter restarts on entry to FETCH or MEM.
    // It advances on every cycle the request goes unanswered.
    // An ack always beats the timeout, even on the final cycle.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        trapCause_d = trapCause_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (timeoutHit) begin
                    state_d     = S_TRAP;
                    trapCause_d = 1'b0;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (isLoad_q || isStore_q) begin
                    state_d   = S_MEM;
                    waitCnt_d = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (timeoutHit) begin
                    state_d     = S_TRAP;
                    trapCause_d = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                if (halt_q) begin
                    state_d = S_HALT;
                end else begin
                    state_d   = S_FETCH;
                    waitCnt_d = '0;
                end
            end
            S_HALT: state_d = S_HALT;
            S_TRAP: state_d = S_TRAP;
            default: begin
                state_d   = S_FETCH;
                waitCnt_d = '0;
            end
        endcase
    end

    // Strobes decode from the current state and the latched flags.
    // While reset is held, every strobe stays quiet, even mid-handshake.
    always_comb begin
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_write_en = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        halted      = 1'b0;
        trap        = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = isStore_q;
                end
                S_WB: begin
                    rf_write_en = wbEn_q && (rd_q != 5'd0) && !isStore_q;
                    pc_we       = 1'b1;
                    pc_sel      = jump_q;
                end
                S_HALT: halted = 1'b1;
                S_TRAP: trap   = 1'b1;
                default: ;
            endcase
        end
    end

    assign rf_write_addr = reset ? 5'd0 : rd_q;
    assign stage         = state_q;
    assign trap_cause    = trapCause_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed testbench for core_seq_ctrl.
// It steps instructions through the sequencer and compares the strobes
// against hand-computed expected values.
module tb_core_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack, dmem_ack;
    logic        dec_is_load, dec_is_store, dec_wb_en, dec_jump, dec_halt;
    logic [4:0]  dec_rd;
    logic        imem_req, ir_we, dmem_req, dmem_we, rf_write_en;
    logic [4:0]  rf_write_addr;
    logic        pc_we, pc_sel, halted, trap, trap_cause;
    logic [2:0]  stage;
    logic [31:0] instret;

    int testsRun    = 0;
    int testsFailed = 0;

    core_seq_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .dec_wb_en(dec_wb_en), .dec_rd(dec_rd),
        .dec_jump(dec_jump), .dec_halt(dec_halt),
        .imem_req(imem_req), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
        .pc_we(pc_we), .pc_sel(pc_sel), .stage(stage),
        .halted(halted), .trap(trap), .trap_cause(trap_cause),
        .instret(instret)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Bounds the whole run in case the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic st, input logic wb,
                                 input logic [4:0] rd, input logic jmp, input logic hlt);
        dec_is_load  = ld;
        dec_is_store = st;
        dec_wb_en    = wb;
        dec_rd       = rd;
        dec_jump     = jmp;
        dec_halt     = hlt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs FETCH with an immediate ack, then DECODE, and stops in EXEC.
    // The decoder inputs are scrambled once DECODE is over.
    task automatic fetchDecode(input logic ld, input logic st, input logic wb,
                               input logic [4:0] rd, input logic jmp, input logic hlt);
        imem_ack = 1'b1;
        applyStimulus(ld, st, wb, rd, jmp, hlt);
        #1;
        checkOutput("fetch ir_we", 32'(ir_we), 32'd1);
        tick;
        checkOutput("decode stage", 32'(stage), 32'd1);
        imem_ack = 1'b0;
        tick;
        checkOutput("exec stage", 32'(stage), 32'd2);
        checkOutput("exec pc_we", 32'(pc_we), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd31, 1'b1, 1'b0);
    endtask

    task automatic doReset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Reset for two cycles; all strobes quiet.
        tick;
        tick;
        checkOutput("reset imem_req", 32'(imem_req), 32'd0);
        checkOutput("reset pc_we", 32'(pc_we), 32'd0);
        checkOutput("reset rf_addr", 32'(rf_write_addr), 32'd0);
        checkOutput("reset instret", instret, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post-reset stage", 32'(stage), 32'd0);
        checkOutput("post-reset imem_req", 32'(imem_req), 32'd1);

        // ALU op, rd = 5.
        fetchDecode(1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
        tick;
        checkOutput("alu wb stage", 32'(stage), 32'd4);
        checkOutput("alu rf_we", 32'(rf_write_en), 32'd1);
        checkOutput("alu rf_addr", 32'(rf_write_addr), 32'd5);
        checkOutput("alu pc_we", 32'(pc_we), 32'd1);
        checkOutput("alu pc_sel", 32'(pc_sel), 32'd0);
        tick;
        checkOutput("alu back stage", 32'(stage), 32'd0);
        checkOutput("alu instret", instret, 32'd1);

        // Load: dmem_ack delayed 3 cycles, so MEM lasts 4 cycles.
        // A stray imem_ack arrives mid-MEM.
        fetchDecode(1'b1, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0);
        tick;
        for (int i = 0; i < 4; i++) begin
            checkOutput("load mem stage", 32'(stage), 32'd3);
            checkOutput("load dmem_req", 32'(dmem_req), 32'd1);
            checkOutput("load dmem_we", 32'(dmem_we), 32'd0);
            imem_ack = (i == 1);
            dmem_ack = (i == 3);
            tick;
        end
        dmem_ack = 1'b0;
        imem_ack = 1'b0;
        checkOutput("load wb stage", 32'(stage), 32'd4);
        checkOutput("load rf_we", 32'(rf_write_en), 32'd1);
        checkOutput("load rf_addr", 32'(rf_write_addr), 32'd10);
        tick;
        checkOutput("load instret", instret, 32'd2);

        // Store: dmem_we in MEM, no register write in WB.
        fetchDecode(1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
        tick;
        checkOutput("store dmem_we", 32'(dmem_we), 32'd1);
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        checkOutput("store wb stage", 32'(stage), 32'd4);
        checkOutput("store rf_we", 32'(rf_write_en), 32'd0);
        checkOutput("store pc_we", 32'(pc_we), 32'd1);
        tick;

        // A stray dmem_ack in FETCH must not advance.
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        checkOutput("stray dmem stage", 32'(stage), 32'd0);

        // Jump with rd = 0: no register write, branch target selected.
        fetchDecode(1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
        tick;
        checkOutput("rd0 rf_we", 32'(rf_write_en), 32'd0);
        checkOutput("jump pc_sel", 32'(pc_sel), 32'd1);
        tick;
        checkOutput("jump instret", instret, 32'd4);

        // Halt: retires, then parks with strobes quiet despite acks.
        fetchDecode(1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1);
        tick;
        checkOutput("halt wb pc_we", 32'(pc_we), 32'd1);
        checkOutput("halt wb rf_we", 32'(rf_write_en), 32'd1);
        for (int i = 0; i < 11; i++) begin
            imem_ack = i[0];
            dmem_ack = ~i[0];
            tick;
            checkOutput("halt stage", 32'(stage), 32'd5);
            checkOutput("halt halted", 32'(halted), 32'd1);
            checkOutput("halt quiet", {27'd0, imem_req, dmem_req, pc_we, rf_write_en, ir_we}, 32'd0);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        checkOutput("halt instret", instret, 32'd5);
        doReset;
        checkOutput("halt reset stage", 32'(stage), 32'd0);
        checkOutput("halt reset instret", instret, 32'd0);

        // Fetch timeout: imem_req is held exactly 16 cycles, then TRAP.
        for (int i = 0; i < 16; i++) begin
            checkOutput("ftmo imem_req", 32'(imem_req), 32'd1);
            tick;
        end
        checkOutput("ftmo stage", 32'(stage), 32'd6);
        checkOutput("ftmo trap", 32'(trap), 32'd1);
        checkOutput("ftmo cause", 32'(trap_cause), 32'd0);
        checkOutput("ftmo imem_req off", 32'(imem_req), 32'd0);
        tick;
        checkOutput("ftmo stays", 32'(stage), 32'd6);
        doReset;

        // Ack on the 16th cycle wins over the timeout.
        for (int i = 0; i < 15; i++) tick;
        checkOutput("late ack still fetch", 32'(stage), 32'd0);
        imem_ack = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        tick;
        imem_ack = 1'b0;
        checkOutput("late ack decode", 32'(stage), 32'd1);
        checkOutput("late ack no trap", 32'(trap), 32'd0);
        tick;
        tick;

        // Data timeout: dmem_req is held 16 cycles, then TRAP with cause 1.
        for (int i = 0; i < 16; i++) begin
            checkOutput("dtmo dmem_req", 32'(dmem_req), 32'd1);
            tick;
        end
        checkOutput("dtmo stage", 32'(stage), 32'd6);
        checkOutput("dtmo trap", 32'(trap), 32'd1);
        checkOutput("dtmo cause", 32'(trap_cause), 32'd1);
        doReset;
        checkOutput("dtmo reset cause", 32'(trap_cause), 32'd0);

        // Reset mid-MEM: back to FETCH with no write or PC strobe.
        fetchDecode(1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        tick;
        checkOutput("midmem dmem_req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midmem rst dmem_req", 32'(dmem_req), 32'd0);
        tick;
        reset = 1'b0;
        #1;
        checkOutput("midmem stage", 32'(stage), 32'd0);
        checkOutput("midmem rf_we", 32'(rf_write_en), 32'd0);
        checkOutput("midmem pc_we", 32'(pc_we), 32'd0);

        // instret wrap from 0xFFFFFFFF to 0.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        checkOutput("wrap preload", instret, 32'hFFFF_FFFF);
        fetchDecode(1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
        tick;
        tick;
        checkOutput("wrap instret", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
